// File: rtl/pipe_scheduler_pkg.sv
// Shared definitions for the pipe scheduler slice.
// Holds the scene encodings, the per-pipe gap record layout, the default pipe
// count, the LFSR feedback mask, and a byte-rotate helper used when a pipe
// picks a new gap height.
package pipe_scheduler_pkg;

  localparam int N_PIPE_DEF = 3;

  localparam logic [1:0] SCENE_SPLASH   = 2'd0;
  localparam logic [1:0] SCENE_PLAYING  = 2'd1;
  localparam logic [1:0] SCENE_GAMEOVER = 2'd2;

  // One pipe on the gaps bus: {position, max_bnd, min_bnd}, 8 bits each.
  localparam int FIELD_W = 8;
  localparam int GAP_W   = 3 * FIELD_W;

  typedef struct packed {
    logic [FIELD_W-1:0] position;
    logic [FIELD_W-1:0] max_bnd;
    logic [FIELD_W-1:0] min_bnd;
  } gap_t;

  localparam logic [7:0] LFSR_MASK = 8'hB8;

  // Rotate left by n (mod 8): the top byte of {v, v} << n.
  function automatic logic [7:0] rotl8(input logic [7:0] v, input int unsigned n);
    logic [15:0] w;
    w = {v, v} << (n % 8);
    return w[15:8];
  endfunction

endpackage

// File: rtl/pipe_scheduler_if.sv
// Bus between the controller side (keys, bird, terminal size) and the pipe
// scheduler, plus the scene/gaps/score/hit outputs the view block draws.
//   start  : one-cycle start/restart request
//   n_row  : terminal rows,    n_col : terminal columns
//   bird   : {altitude[7:0], is_flapping}
//   scene  : 0 splash, 1 playing, 2 game over
//   gaps   : pipe i at gaps[24*i +: 24] = {position, max_bnd, min_bnd}
//   score  : pipes passed, saturating
//   hit    : one-cycle pulse when the game ends
interface pipe_scheduler_if
  import pipe_scheduler_pkg::*;
#(
  parameter int N_PIPE = N_PIPE_DEF
);
  logic                      start;
  logic [7:0]                n_row;
  logic [7:0]                n_col;
  logic [8:0]                bird;
  logic [1:0]                scene;
  logic [GAP_W*N_PIPE-1:0]   gaps;
  logic [7:0]                score;
  logic                      hit;

  modport master (
    output start, n_row, n_col, bird,
    input  scene, gaps, score, hit
  );

  modport slave (
    input  start, n_row, n_col, bird,
    output scene, gaps, score, hit
  );
endinterface

// File: rtl/pipe_lfsr.sv
// 8-bit Galois LFSR that advances every clock and is reloaded only by rst.
//   clk  : system clock
//   rst  : synchronous active-high reset, loads SEED
//   lfsr : current register value
module pipe_lfsr
  import pipe_scheduler_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] lfsr
);

  always_ff @(posedge clk) begin
    if (rst) lfsr <= SEED;
    else     lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? LFSR_MASK : 8'h00);
  end

endmodule

// File: rtl/pipe_scheduler.sv
// Pipe field owner: scrolls the pipes left, recycles pipes that reach the left
// edge with a pseudo-random gap, detects bird collisions and keeps the score,
// while sequencing splash / playing / game over.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : pipe_scheduler_if.slave (start, n_row, n_col, bird in;
//         scene, gaps, score, hit out)
//
// state          | meaning
// SCENE_SPLASH   | gaps held, waiting for start
// SCENE_PLAYING  | pipes scroll every SCROLL_DIV ticks, collisions checked
// SCENE_GAMEOVER | gaps and score frozen, start returns to splash
module pipe_scheduler
  import pipe_scheduler_pkg::*;
#(
  parameter int N_PIPE      = N_PIPE_DEF,
  parameter int SCROLL_DIV  = 4,
  parameter int LEFT_EDGE   = 2,
  parameter int BIRD_COL_HI = 8,
  parameter int GAP_H       = 10,
  parameter int MIN_FLOOR   = 5,
  parameter logic [7:0] SEED = 8'hA5,
  parameter logic [GAP_W*N_PIPE-1:0] INIT_GAPS =
    {8'd20, 8'd30, 8'd20, 8'd40, 8'd25, 8'd15, 8'd60, 8'd35, 8'd25}
) (
  input  logic           clk,
  input  logic           rst,
  pipe_scheduler_if.slave bus
);

  localparam logic [7:0] TICK_LAST = 8'(SCROLL_DIV - 1);

  logic [1:0]              scene_q;
  logic [GAP_W*N_PIPE-1:0] gaps_q;
  logic [GAP_W*N_PIPE-1:0] gaps_step;
  logic [7:0]              score_q;
  logic [7:0]              score_step;
  logic [8:0]              score_sum;
  logic                    hit_q;
  logic [7:0]              tick_q;
  logic [7:0]              lfsr;
  logic [7:0]              altitude;
  logic [7:0]              lim;
  logic [N_PIPE-1:0]       recycle;
  logic [N_PIPE-1:0]       pipe_hit;
  logic                    collision;
  logic                    step;
  logic                    unused_flap;

  pipe_lfsr #(.SEED(SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr)
  );

  assign altitude    = bus.bird[8:1];
  assign unused_flap = bus.bird[0];
  // Wraps for tiny terminals; the gap is then nonsense but never X.
  assign lim         = bus.n_row - 8'(GAP_H) - 8'd1;

  for (genvar i = 0; i < N_PIPE; i++) begin : g_pipe
    gap_t       cur;
    gap_t       nxt;
    logic [7:0] r;
    logic [7:0] cand;
    logic [7:0] new_min;

    assign cur     = gaps_q[GAP_W*i +: GAP_W];
    // Each pipe sees a differently rotated LFSR so simultaneous recycles differ.
    assign r       = rotl8(lfsr, i);
    assign cand    = 8'(MIN_FLOOR) + {2'b00, r[5:0]};
    assign new_min = (cand < lim) ? cand : lim;

    assign recycle[i]  = cur.position <= 8'(LEFT_EDGE);
    assign pipe_hit[i] = (cur.position <= 8'(BIRD_COL_HI)) &&
                         ((altitude >= cur.max_bnd) || (altitude <= cur.min_bnd));

    always_comb begin
      nxt = cur;
      if (recycle[i]) begin
        nxt.position = bus.n_col - 8'd2;
        nxt.min_bnd  = new_min;
        nxt.max_bnd  = new_min + 8'(GAP_H);
      end else begin
        nxt.position = cur.position - 8'd1;
      end
    end

    assign gaps_step[GAP_W*i +: GAP_W] = nxt;
  end

  always_comb begin
    score_sum = {1'b0, score_q};
    for (int i = 0; i < N_PIPE; i++) score_sum = score_sum + {8'd0, recycle[i]};
    score_step = score_sum[8] ? 8'hFF : score_sum[7:0];
  end

  assign collision = (scene_q == SCENE_PLAYING) && ((altitude == 8'd0) || (|pipe_hit));
  assign step      = tick_q == TICK_LAST;

  always_ff @(posedge clk) begin
    if (rst) begin
      scene_q <= SCENE_SPLASH;
      gaps_q  <= INIT_GAPS;
      score_q <= 8'd0;
      hit_q   <= 1'b0;
      tick_q  <= 8'd0;
    end else begin
      hit_q <= 1'b0;
      case (scene_q)
        SCENE_SPLASH: begin
          if (bus.start) begin
            scene_q <= SCENE_PLAYING;
            tick_q  <= 8'd0;
          end
        end
        SCENE_PLAYING: begin
          // A collision pre-empts any scroll step due on the same cycle.
          if (collision) begin
            scene_q <= SCENE_GAMEOVER;
            hit_q   <= 1'b1;
          end else if (step) begin
            tick_q  <= 8'd0;
            gaps_q  <= gaps_step;
            score_q <= score_step;
          end else begin
            tick_q  <= tick_q + 8'd1;
          end
        end
        SCENE_GAMEOVER: begin
          if (bus.start) begin
            scene_q <= SCENE_SPLASH;
            gaps_q  <= INIT_GAPS;
            score_q <= 8'd0;
            tick_q  <= 8'd0;
          end
        end
        default: scene_q <= SCENE_SPLASH;
      endcase
    end
  end

  assign bus.scene = scene_q;
  assign bus.gaps  = gaps_q;
  assign bus.score = score_q;
  assign bus.hit   = hit_q;

endmodule

// File: doc/pipe_scheduler.md
Name: pipe_scheduler

Overview:
Owns the pipe field for the game: scrolls the N_PIPE pipe gaps leftward, recycles pipes that leave the screen with a pseudo-random gap, detects bird/pipe and bird/ground collision, and keeps the score.
Sequences the game scene (splash/playing/game over) and drives the scene and gaps buses that the view block draws.
Sits between io/controller (keys, bird) and view.

Parameters:
N_PIPE, 3, number of pipe gaps managed
SCROLL_DIV, 4, clock ticks per one-column scroll step (>=1)
LEFT_EDGE, 2, position at which a pipe is recycled
BIRD_COL_HI, 8, largest pipe position whose body overlaps the bird columns
GAP_H, 10, max_bnd - min_bnd for recycled pipes
MIN_FLOOR, 5, lowest min_bnd for recycled pipes
SEED, 8'hA5, LFSR reset value (nonzero)
INIT_GAPS, {20,30,20, 40,25,15, 60,35,25} (9x8 bit), layout loaded on reset and on restart

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle start/restart request (space key)
n_row  in  8  terminal rows, sampled live
n_col  in  8  terminal columns, sampled live
bird  in  9  {altitude[7:0], is_flapping}
scene  out  2  0 splash, 1 playing, 2 game over
gaps  out  24*N_PIPE  pipe i at gaps[24*i+:24] = {position, max_bnd, min_bnd}
score  out  8  pipes passed, saturating
hit  out  1  one-cycle pulse on the cycle scene enters game over

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst). rst wins over every other input.
- Reset values: scene=0, gaps=INIT_GAPS, score=0, hit=0, tick counter=0, lfsr=SEED.
- LFSR: 8-bit Galois, mask 8'hB8, shifts every cycle in all scenes. It is never reloaded except by rst.
- SPLASH (0): gaps held. When start=1, go to PLAYING next cycle and clear the tick counter.
- PLAYING (1):
  - The tick counter counts 0..SCROLL_DIV-1. A step occurs on the cycle it equals SCROLL_DIV-1, and the counter then wraps to 0.
  - On a step, for each pipe: if position > LEFT_EDGE, position decrements by 1.
  - On a step, a pipe with position <= LEFT_EDGE recycles:
    - position <= n_col-2
    - r = lfsr rotated left by i; cand = MIN_FLOOR + r[5:0]; lim = n_row-GAP_H-1
    - min_bnd <= min(cand, lim); max_bnd <= min_bnd+GAP_H
  - Score adds the number of pipes recycled on that step, saturating at 255.
  - start is ignored in PLAYING.
- Collision, evaluated every PLAYING cycle from the registered gaps and the current bird:
  - altitude==0, or
  - for any pipe, position <= BIRD_COL_HI and (altitude >= max_bnd or altitude <= min_bnd).
  - On a collision cycle: next cycle scene=2 and hit=1 for exactly one cycle. No step and no score update are applied that cycle, even if the tick counter is at SCROLL_DIV-1.
- GAME OVER (2): gaps and score frozen. When start=1, next cycle scene=0, gaps=INIT_GAPS, score=0, tick counter=0.
- Arithmetic: 8-bit unsigned throughout. The lim computation assumes n_row > GAP_H+MIN_FLOOR+1. Smaller n_row is out of contract, but the result must not be X.
- Latency: start to scene change 1 cycle; collision to scene=2/hit 1 cycle; step to gaps update 1 cycle (registered outputs).

Decomposition:
- Shared package/header: scene encodings (SCENE_SPLASH/PLAYING/GAMEOVER), gap field offsets and widths, N_PIPE default, LFSR mask.
- One sub-module, pipe_lfsr (8-bit Galois LFSR with seed parameter and rst). Per-pipe update logic is a generate loop, not a sub-module.

Test Plan:
- Reset: rst high 2 cycles -> scene=0, score=0, hit=0, gaps = {20,30,20,40,25,15,60,35,25}. Gaps remain unchanged over 20 further idle cycles.
- Scroll: start pulse with n_row=40, n_col=80, altitude=20 -> scene=1. After 4 PLAYING cycles, positions are 59/39/19; after 8 cycles, 58/38/18.
- Recycle: pipe0 at position 2, n_row=40, n_col=80; step occurs -> pipe0 position=78, min_bnd=min(5+r[5:0],29), max_bnd=min_bnd+10, score=1. With the LFSR forced so the offset is 63: min_bnd=29, max_bnd=39.
- Collision:
  - pipe at position 8, bounds 35/25, altitude=36 -> next cycle scene=2, hit=1 for one cycle, gaps frozen.
  - Same with altitude=30 -> no hit.
  - Position 9 with altitude=36 -> no hit.
- Ground and simultaneity: altitude=0 on a step cycle -> scene=2 and positions not decremented. Pipe recycle coinciding with collision -> score unchanged.
- Restart/reset: start in scene 2 -> scene=0, INIT_GAPS, score=0. rst asserted mid-PLAYING together with start -> scene=0, INIT_GAPS. LFSR back to 8'hA5 only on rst.
